rsa256_uart_wrapper: RTL and testbench
======================================

# rsa256_uart_wrapper

- Avalon-MM master that connects an RS232 UART core to the RSA256 decryption core.
- Receives the 256-bit modulus N and private key D byte-serially, then repeatedly:
  - receives a 256-bit cipher block;
  - starts the decryption core and waits for it to finish;
  - transmits the 31-byte (248-bit) plaintext back over the UART.
- Sits between the Qsys UART and the RSA core.
- Drives the core's start/operand inputs and consumes its result/finished outputs.

## Interface

Parameters:
- RX_BASE, 0: UART receive-data register address
- TX_BASE, 4: UART transmit-data register address
- STATUS_BASE, 8: UART status register address
- RX_OK_BIT, 7: status bit, RX byte available
- TX_OK_BIT, 6: status bit, TX ready

Clock and reset are fixed: one clock; reset is asynchronous and active-high.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous active-high reset
- avm_address  out  5  Avalon address
- avm_read  out  1  Avalon read request
- avm_readdata  in  32  Avalon read data, valid when avm_waitrequest low
- avm_write  out  1  Avalon write request
- avm_writedata  out  32  Avalon write data, byte in [7:0], upper bits 0
- avm_waitrequest  in  1  slave stall
- o_core_start  out  1  one-cycle start pulse to RSA core
- o_core_a  out  256  cipher block
- o_core_d  out  256  private key
- o_core_n  out  256  modulus
- i_core_a_pow_d  in  270  core result, bits [247:0] used
- i_core_finished  in  1  core done pulse

## Operation

- Every output is registered.
- Reset values:
  - avm_address = STATUS_BASE
  - avm_read = 1
  - avm_write = 0
  - avm_writedata = 0
  - o_core_start = 0
  - o_core_a/d/n = 0
- Byte counter (0..31) reset to 0. Phase register (PH_N, PH_D, PH_A) reset to PH_N.
- State machine:
  - S_QUERY_RX: read STATUS_BASE. On completion, if readdata[RX_OK_BIT]=1, go to S_READ with address RX_BASE; else stay and re-poll back-to-back (read stays high).
  - S_READ: on completion, shift readdata[7:0] into the LSB of the phase's register (first byte ends up MSB). Increment the byte counter.
    - If counter was 31: clear it and advance the phase.
      - PH_N→PH_D, return to S_QUERY_RX.
      - PH_D→PH_A, return to S_QUERY_RX.
      - PH_A: deassert read, pulse o_core_start for one cycle, go to S_WAIT_CALC.
    - Otherwise return to S_QUERY_RX with address STATUS_BASE.
  - S_WAIT_CALC: no bus activity. On i_core_finished=1, latch i_core_a_pow_d[247:0] into the output shift register, go to S_QUERY_TX with read asserted to STATUS_BASE.
  - S_QUERY_TX: poll status. On completion with readdata[TX_OK_BIT]=1, deassert read and go to S_WRITE: address TX_BASE, write=1, writedata = {24'b0, out[247:240]}.
  - S_WRITE: on completion, shift the output register left by 8 and increment the counter.
    - If the counter was 30: clear it, go to S_QUERY_RX with phase PH_A. N and D are retained.
    - Otherwise return to S_QUERY_TX.
- Avalon rules:
  - address, read, write and writedata are held constant while avm_waitrequest=1.
  - A transaction completes in exactly one cycle with avm_waitrequest=0.
  - read and write are never high together.
- i_core_finished outside S_WAIT_CALC is ignored.
- o_core_a/d/n are stable from o_core_start until the next cipher byte is received.
- Reset mid-operation (any state) returns to reset values immediately. A new session restarts with N.

## Timing

- With waitrequest low and status ready, one received byte costs 2 cycles (poll + read). One transmitted byte also costs 2 cycles.
- o_core_start is high in the cycle after the 32nd cipher-byte read completes.
- The first TX status poll is issued in the cycle after i_core_finished is sampled high.
- Each additional waitrequest cycle adds exactly one cycle. No bytes are dropped or duplicated.

## Structure

- Shared package holds:
  - the state enum (S_QUERY_RX, S_READ, S_WAIT_CALC, S_QUERY_TX, S_WRITE);
  - the phase enum;
  - the address/bit constants as defaults.
- No sub-module: a single FSM with shift registers.
- The RSA core is instantiated by the top level, not inside this block.

## Test plan

- Reset: after i_rst, check the reset values listed above. Release reset with status bit7=0: read is held at STATUS_BASE and o_core_start is never asserted.
- Key load: feed 64 bytes 0x00..0x3F.
  - Expect o_core_n=0x000102…1F and o_core_d=0x202122…3F.
  - o_core_start stays 0.
- Cipher: after keys, feed 32 bytes 0xA0..0xBF.
  - Expect o_core_a=0xA0A1…BF.
  - Expect exactly one 1-cycle start pulse, then no Avalon traffic until finished.
- Result: core model pulses finished with i_core_a_pow_d[247:0]=0x0102…1F.
  - Expect 31 TX_BASE writes 0x01..0x1F in order, each preceded by a status poll.
  - Holding bit6=0 for 5 polls delays the write by 5 polls.
  - The block then returns to polling RX.
- Waitrequest: stretch every transaction by 3 cycles.
  - Outputs stay stable while stalled.
  - Each byte is captured or written exactly once.
  - Results match the no-stall run.
- Reset mid-send: assert i_rst after the 10th TX write.
  - Outputs return to reset values.
  - The next 96 bytes are interpreted as N, D, A.

Source files
------------

// File: rtl/rsa256_uart_wrapper_pkg.sv
// Shared types and default register map for the UART-to-RSA256 bridge.
package rsa256_uart_wrapper_pkg;

    typedef enum logic [2:0] {
        S_QUERY_RX,
        S_READ,
        S_WAIT_CALC,
        S_QUERY_TX,
        S_WRITE
    } state_t;

    typedef enum logic [1:0] {
        PH_N,
        PH_D,
        PH_A
    } phase_t;

    localparam logic [4:0] RX_BASE_DEF     = 5'd0;
    localparam logic [4:0] TX_BASE_DEF     = 5'd4;
    localparam logic [4:0] STATUS_BASE_DEF = 5'd8;
    localparam int         RX_OK_BIT_DEF   = 7;
    localparam int         TX_OK_BIT_DEF   = 6;

    // Last counter value of a 32-byte operand and of the 31-byte plaintext.
    localparam logic [4:0] LAST_RX_BYTE = 5'd31;
    localparam logic [4:0] LAST_TX_BYTE = 5'd30;

endpackage

// File: rtl/rsa256_uart_wrapper.sv
// Avalon-MM master that loads N, D and cipher blocks from a UART into the
// RSA256 core and streams each 248-bit plaintext back out byte by byte.
module rsa256_uart_wrapper
    import rsa256_uart_wrapper_pkg::*;
#(
    parameter logic [4:0] RX_BASE     = RX_BASE_DEF,
    parameter logic [4:0] TX_BASE     = TX_BASE_DEF,
    parameter logic [4:0] STATUS_BASE = STATUS_BASE_DEF,
    parameter int         RX_OK_BIT   = RX_OK_BIT_DEF,
    parameter int         TX_OK_BIT   = TX_OK_BIT_DEF
) (
    input  logic         i_clk,
    input  logic         i_rst,
    output logic [4:0]   avm_address,
    output logic         avm_read,
    input  logic [31:0]  avm_readdata,
    output logic         avm_write,
    output logic [31:0]  avm_writedata,
    input  logic         avm_waitrequest,
    output logic         o_core_start,
    output logic [255:0] o_core_a,
    output logic [255:0] o_core_d,
    output logic [255:0] o_core_n,
    input  logic [269:0] i_core_a_pow_d,
    input  logic         i_core_finished
);

    state_t         state_reg;
    phase_t         phase_reg;
    logic [4:0]     cnt_reg;
    logic [4:0]     address_reg;
    logic           read_reg;
    logic           write_reg;
    logic [31:0]    writedata_reg;
    logic           start_reg;
    logic [255:0]   n_reg;
    logic [255:0]   d_reg;
    logic [255:0]   a_reg;
    logic [247:0]   out_reg;

    logic [7:0]     rx_byte;
    logic           unused_inputs;

    assign rx_byte       = avm_readdata[7:0];
    assign unused_inputs = ^{i_core_a_pow_d[269:248], avm_readdata[31:8]};

    assign avm_address   = address_reg;
    assign avm_read      = read_reg;
    assign avm_write     = write_reg;
    assign avm_writedata = writedata_reg;
    assign o_core_start  = start_reg;
    assign o_core_n      = n_reg;
    assign o_core_d      = d_reg;
    assign o_core_a      = a_reg;

    // Every bus-facing update is gated on !avm_waitrequest so that request
    // signals hold steady for the whole stall.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg     <= S_QUERY_RX;
            phase_reg     <= PH_N;
            cnt_reg       <= '0;
            address_reg   <= STATUS_BASE;
            read_reg      <= 1'b1;
            write_reg     <= 1'b0;
            writedata_reg <= '0;
            start_reg     <= 1'b0;
            n_reg         <= '0;
            d_reg         <= '0;
            a_reg         <= '0;
            out_reg       <= '0;
        end else begin
            start_reg <= 1'b0;
            case (state_reg)
                S_QUERY_RX: begin
                    if (!avm_waitrequest && avm_readdata[RX_OK_BIT]) begin
                        state_reg   <= S_READ;
                        address_reg <= RX_BASE;
                    end
                end

                S_READ: begin
                    if (!avm_waitrequest) begin
                        case (phase_reg)
                            PH_N:    n_reg <= {n_reg[247:0], rx_byte};
                            PH_D:    d_reg <= {d_reg[247:0], rx_byte};
                            default: a_reg <= {a_reg[247:0], rx_byte};
                        endcase
                        if (cnt_reg == LAST_RX_BYTE) begin
                            cnt_reg <= '0;
                            case (phase_reg)
                                PH_N: begin
                                    phase_reg   <= PH_D;
                                    state_reg   <= S_QUERY_RX;
                                    address_reg <= STATUS_BASE;
                                end
                                PH_D: begin
                                    phase_reg   <= PH_A;
                                    state_reg   <= S_QUERY_RX;
                                    address_reg <= STATUS_BASE;
                                end
                                default: begin
                                    read_reg  <= 1'b0;
                                    start_reg <= 1'b1;
                                    state_reg <= S_WAIT_CALC;
                                end
                            endcase
                        end else begin
                            cnt_reg     <= cnt_reg + 5'd1;
                            state_reg   <= S_QUERY_RX;
                            address_reg <= STATUS_BASE;
                        end
                    end
                end

                S_WAIT_CALC: begin
                    if (i_core_finished) begin
                        out_reg     <= i_core_a_pow_d[247:0];
                        state_reg   <= S_QUERY_TX;
                        read_reg    <= 1'b1;
                        address_reg <= STATUS_BASE;
                    end
                end

                S_QUERY_TX: begin
                    if (!avm_waitrequest && avm_readdata[TX_OK_BIT]) begin
                        read_reg      <= 1'b0;
                        write_reg     <= 1'b1;
                        address_reg   <= TX_BASE;
                        writedata_reg <= {24'b0, out_reg[247:240]};
                        state_reg     <= S_WRITE;
                    end
                end

                S_WRITE: begin
                    if (!avm_waitrequest) begin
                        out_reg     <= {out_reg[239:0], 8'h00};
                        write_reg   <= 1'b0;
                        read_reg    <= 1'b1;
                        address_reg <= STATUS_BASE;
                        if (cnt_reg == LAST_TX_BYTE) begin
                            // Keys stay loaded; only a fresh cipher block is expected next.
                            cnt_reg   <= '0;
                            phase_reg <= PH_A;
                            state_reg <= S_QUERY_RX;
                        end else begin
                            cnt_reg   <= cnt_reg + 5'd1;
                            state_reg <= S_QUERY_TX;
                        end
                    end
                end

                default: begin
                    state_reg   <= S_QUERY_RX;
                    read_reg    <= 1'b1;
                    write_reg   <= 1'b0;
                    address_reg <= STATUS_BASE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rsa256_uart_wrapper.sv
// Bench for rsa256_uart_wrapper: UART/Avalon slave and RSA core models plus a
// transaction-level scoreboard checked every cycle, and directed session tests.
module tb_rsa256_uart_wrapper;

    localparam logic [4:0] RX_A     = 5'd0;
    localparam logic [4:0] TX_A     = 5'd4;
    localparam logic [4:0] STATUS_A = 5'd8;
    localparam int         CALC_LAT = 8;

    logic         i_clk = 1'b0;
    logic         i_rst = 1'b1;
    logic [4:0]   avm_address;
    logic         avm_read;
    logic [31:0]  avm_readdata = '0;
    logic         avm_write;
    logic [31:0]  avm_writedata;
    logic         avm_waitrequest = 1'b0;
    logic         o_core_start;
    logic [255:0] o_core_a;
    logic [255:0] o_core_d;
    logic [255:0] o_core_n;
    logic [269:0] i_core_a_pow_d = '0;
    logic         i_core_finished = 1'b0;

    int checks = 0;
    int errors = 0;

    // Stimulus-side controls
    logic [7:0]   rx_q[$];
    int           stall_cfg = 0;
    int           tx_block_arm = 0;
    logic         spur_req = 1'b0;
    logic [247:0] result_val = '0;

    // Scoreboard / model state
    int           sess_cnt = 0;
    logic [255:0] exp_n = '0, exp_d = '0, exp_a = '0;
    logic         exp_start = 1'b0;
    logic [7:0]   tx_exp[$];
    logic [7:0]   tx_log[$];
    int           tx_total = 0;
    int           starts_seen = 0;
    int           polls = 0, polls_exp = 1;
    int           last_kind = 0;
    logic [7:0]   last_stat = '0;
    int           stall_left = 0;
    int           tx_block = 0;
    logic         calc_busy = 1'b0, fin_drv = 1'b0;
    int           calc_timer = 0;
    logic         l_valid = 1'b0, l_wait = 1'b0, l_rd = 1'b0, l_wr = 1'b0;
    logic [4:0]   l_addr = '0;
    logic [31:0]  l_wd = '0, l_rdata = '0;

    rsa256_uart_wrapper dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_readdata    (avm_readdata),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_waitrequest (avm_waitrequest),
        .o_core_start    (o_core_start),
        .o_core_a        (o_core_a),
        .o_core_d        (o_core_d),
        .o_core_n        (o_core_n),
        .i_core_a_pow_d  (i_core_a_pow_d),
        .i_core_finished (i_core_finished)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string nm, input logic [269:0] act, input logic [269:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Slave, core model and scoreboard: completions of the previous edge are
    // scored first, then the slave response for the next edge is driven.
    always @(negedge i_clk) begin
        if (i_rst) begin
            sess_cnt = 0; exp_n = '0; exp_d = '0; exp_a = '0; exp_start = 1'b0;
            tx_exp.delete(); calc_busy = 1'b0; fin_drv = 1'b0; calc_timer = 0;
            polls = 0; polls_exp = 1; last_kind = 0; last_stat = '0;
            l_valid = 1'b0; l_wait = 1'b0; stall_left = stall_cfg; tx_block = 0;
            i_core_finished = 1'b0; avm_waitrequest = 1'b0; avm_readdata = '0;
        end else begin
            chk("rd_wr_excl", avm_read & avm_write, 1'b0);
            if (l_valid && l_wait)
                chk("stall_hold", {avm_address, avm_read, avm_write, avm_writedata},
                    {l_addr, l_rd, l_wr, l_wd});
            if (l_valid && !l_wait) begin
                if (l_rd && l_addr == STATUS_A) begin
                    polls++;
                    last_kind = 1;
                    last_stat = l_rdata[7:0];
                    if (!l_rdata[6] && tx_block > 0) tx_block--;
                end else if (l_rd && l_addr == RX_A) begin
                    int idx;
                    logic [7:0] b;
                    chk("rx_after_poll", (last_kind == 1) && last_stat[7], 1'b1);
                    idx = sess_cnt;
                    b = l_rdata[7:0];
                    if (idx < 32) exp_n[8*(31-idx) +: 8] = b;
                    else if (idx < 64) exp_d[8*(63-idx) +: 8] = b;
                    else exp_a[8*(31-((idx-64)%32)) +: 8] = b;
                    if (idx >= 64 && (idx-64)%32 == 31) exp_start = 1'b1;
                    sess_cnt++;
                    last_kind = 2;
                end else if (l_wr) begin
                    chk("wr_addr", l_addr, TX_A);
                    chk("tx_after_poll", (last_kind == 1) && last_stat[6], 1'b1);
                    chk("tx_poll_count", polls, polls_exp);
                    chk("tx_queue_nonempty", tx_exp.size() != 0, 1'b1);
                    if (tx_exp.size() != 0) chk("tx_byte", l_wd, {24'b0, tx_exp.pop_front()});
                    tx_log.push_back(l_wd[7:0]);
                    tx_total++;
                    polls = 0;
                    polls_exp = 1;
                    last_kind = 3;
                end else begin
                    chk("txn_addr_valid", (l_addr == STATUS_A) || (l_addr == RX_A), 1'b1);
                end
            end

            chk("core_start", o_core_start, exp_start);
            if (o_core_start) starts_seen++;
            if (exp_start) begin
                chk("core_n", o_core_n, exp_n);
                chk("core_d", o_core_d, exp_d);
                chk("core_a", o_core_a, exp_a);
                calc_busy = 1'b1;
                calc_timer = CALC_LAT;
                exp_start = 1'b0;
            end

            i_core_finished = 1'b0;
            if (fin_drv) begin
                chk("tx_first_poll", {avm_read, avm_write, avm_address}, {1'b1, 1'b0, STATUS_A});
                fin_drv = 1'b0;
                calc_busy = 1'b0;
                i_core_a_pow_d = '1;
            end else if (calc_busy) begin
                chk("calc_idle", avm_read | avm_write, 1'b0);
                if (calc_timer == 0) begin
                    i_core_finished = 1'b1;
                    i_core_a_pow_d = {22'h3abcde, result_val};
                    for (int k = 0; k < 31; k++) tx_exp.push_back(result_val[247-8*k -: 8]);
                    polls = 0;
                    tx_block = tx_block_arm;
                    polls_exp = 1 + tx_block_arm;
                    tx_block_arm = 0;
                    fin_drv = 1'b1;
                end else begin
                    calc_timer--;
                end
            end else if (spur_req) begin
                i_core_finished = 1'b1;
                i_core_a_pow_d = {270{1'b1}};
                spur_req = 1'b0;
            end

            avm_waitrequest = 1'b0;
            avm_readdata = '0;
            if (avm_read || avm_write) begin
                if (stall_left > 0) begin
                    avm_waitrequest = 1'b1;
                    stall_left--;
                end else begin
                    stall_left = stall_cfg;
                    if (avm_read && avm_address == STATUS_A)
                        avm_readdata = {24'ha5a5a5, rx_q.size() > 0, tx_block == 0, 6'h3f};
                    else if (avm_read && avm_address == RX_A)
                        avm_readdata = {24'h5a5a5a, (rx_q.size() > 0) ? rx_q.pop_front() : 8'hee};
                end
            end
            l_valid = avm_read | avm_write;
            l_wait = avm_waitrequest;
            l_rd = avm_read;
            l_wr = avm_write;
            l_addr = avm_address;
            l_wd = avm_writedata;
            l_rdata = avm_readdata;
        end
    end

    task automatic chk_reset_values();
        chk("rst_address", avm_address, STATUS_A);
        chk("rst_read", avm_read, 1'b1);
        chk("rst_write", avm_write, 1'b0);
        chk("rst_writedata", avm_writedata, 32'h0);
        chk("rst_start", o_core_start, 1'b0);
        chk("rst_core_a", o_core_a, 256'h0);
        chk("rst_core_d", o_core_d, 256'h0);
        chk("rst_core_n", o_core_n, 256'h0);
    endtask

    task automatic wait_tx(input int target, input int limit);
        for (int i = 0; i < limit && tx_total < target; i++) begin
            @(negedge i_clk); #1;
        end
        chk("tx_total_reached", tx_total, target);
    endtask

    initial begin
        logic [247:0] r3;
        repeat (3) @(negedge i_clk);
        #1;
        chk_reset_values();
        i_rst = 1'b0;

        // Idle with nothing to receive: status polling only
        repeat (30) @(negedge i_clk);
        #1;
        chk("idle_read", {avm_read, avm_write, avm_address}, {1'b1, 1'b0, STATUS_A});
        chk("idle_no_start", starts_seen, 0);

        // Stray finished pulse while receiving must be ignored
        spur_req = 1'b1;
        repeat (20) @(negedge i_clk);
        #1;
        chk("spur_no_tx", tx_total, 0);
        chk("spur_still_rx", {avm_read, avm_address}, {1'b1, STATUS_A});

        // Key load
        for (int b = 0; b < 64; b++) rx_q.push_back(8'(b));
        for (int i = 0; i < 2000 && sess_cnt < 64; i++) begin
            @(negedge i_clk); #1;
        end
        chk("keys_loaded", sess_cnt, 64);
        chk("key_n_lit", o_core_n, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
        chk("key_d_lit", o_core_d, 256'h202122232425262728292a2b2c2d2e2f303132333435363738393a3b3c3d3e3f);
        chk("key_no_start", starts_seen, 0);

        // First cipher block, result with five TX-not-ready polls in front
        result_val = 248'h0102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        tx_block_arm = 5;
        for (int b = 0; b < 32; b++) rx_q.push_back(8'(8'ha0 + b));
        wait_tx(31, 3000);
        chk("cipher_a_lit", o_core_a, 256'ha0a1a2a3a4a5a6a7a8a9aaabacadaeafb0b1b2b3b4b5b6b7b8b9babbbcbdbebf);
        chk("one_start", starts_seen, 1);
        chk("tx_first_lit", tx_log[0], 8'h01);
        chk("tx_last_lit", tx_log[30], 8'h1f);
        repeat (10) @(negedge i_clk);
        #1;
        chk("back_to_rx", {avm_read, avm_write, avm_address}, {1'b1, 1'b0, STATUS_A});

        // Every transaction stretched by three wait cycles
        stall_cfg = 3;
        for (int b = 0; b < 32; b++) rx_q.push_back(8'(8'hc0 + b));
        wait_tx(62, 6000);
        chk("stall_starts", starts_seen, 2);
        chk("stall_first_lit", tx_log[31], 8'h01);
        chk("stall_last_lit", tx_log[61], 8'h1f);
        chk("stall_rx_drained", rx_q.size(), 0);

        // Reset in the middle of sending a result
        stall_cfg = 0;
        for (int b = 0; b < 32; b++) rx_q.push_back(8'(8'he0 + b));
        wait_tx(72, 3000);
        i_rst = 1'b1;
        #1;
        chk_reset_values();
        repeat (3) @(negedge i_clk);
        #1;
        rx_q.delete();
        i_rst = 1'b0;

        // Fresh session: N, D and A all reloaded
        for (int k = 0; k < 31; k++) r3[247-8*k -: 8] = 8'(8'hc0 + k);
        result_val = r3;
        for (int b = 0; b < 96; b++) rx_q.push_back(8'(8'h40 + b));
        wait_tx(103, 4000);
        chk("s3_n_lit", o_core_n, 256'h404142434445464748494a4b4c4d4e4f505152535455565758595a5b5c5d5e5f);
        chk("s3_d_lit", o_core_d, 256'h606162636465666768696a6b6c6d6e6f707172737475767778797a7b7c7d7e7f);
        chk("s3_a_lit", o_core_a, 256'h808182838485868788898a8b8c8d8e8f909192939495969798999a9b9c9d9e9f);
        chk("s3_starts", starts_seen, 4);
        chk("s3_first_lit", tx_log[72], 8'hc0);
        chk("s3_last_lit", tx_log[102], 8'hde);
        chk("tx_log_size", tx_log.size(), 103);
        chk("tx_exp_drained", tx_exp.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
